des_key_sched: RTL and testbench



---
 rtl/des_pkg.sv | 18 +
 rtl/des_key_sched_if.sv | 26 ++
 rtl/des_pc1.sv | 15 +
 rtl/des_key_sched.sv | 86 ++++++++
 tb/tb_des_key_sched.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule types, round count, PC-1 table and sequencer states
package des_pkg;
  localparam int DES_ROUNDS = 16;
  typedef logic [63:0] des_key64_t;
  typedef logic [55:0] des_cd56_t;
  typedef logic [3:0]  des_idx_t;
  typedef enum logic {S_IDLE, S_RUN} des_state_t;
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
endpackage

// File: rtl/des_key_sched_if.sv
// des_key_sched_if: key-load handshake plus beat stream between the sequencer and its peers
interface des_key_sched_if;
  import des_pkg::*;
  des_key64_t key_in;
  logic       key_in_valid;
  logic       key_in_ready;
  logic       decrypt_in;
  logic       round_en_in;
  logic       abort_in;
  des_cd56_t  sub_key_out;
  des_idx_t   sub_key_idx_out;
  logic       sub_key_out_valid;
  logic       sched_busy_out;
  logic       sched_done_out;
  logic       parity_err_out;
  modport master (
    output key_in, key_in_valid, decrypt_in, round_en_in, abort_in,
    input  key_in_ready, sub_key_out, sub_key_idx_out, sub_key_out_valid,
           sched_busy_out, sched_done_out, parity_err_out
  );
  modport slave (
    input  key_in, key_in_valid, decrypt_in, round_en_in, abort_in,
    output key_in_ready, sub_key_out, sub_key_idx_out, sub_key_out_valid,
           sched_busy_out, sched_done_out, parity_err_out
  );
endinterface

// File: rtl/des_pc1.sv
// des_pc1: combinational DES PC-1, 64-bit key (bit 63 = DES bit 1) to C0D0 (bit 55 = PC-1 bit 1)
module des_pc1
  import des_pkg::*;
(
  input  des_key64_t key_i,
  output des_cd56_t  cd_o
);
  logic unused_par;
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign cd_o[55 - i] = key_i[64 - PC1_TBL[i]];
  end
  // parity bits are dropped by PC-1
  assign unused_par = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                        key_i[24], key_i[16], key_i[8], key_i[0]};
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: latches PC-1 of an accepted key, then emits round-index beats paced by round_en_in
// DES_KEY_PARITY_CHK_EN: reject keys whose bytes lack odd parity
module des_key_sched
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS
) (
  input logic            clk_in,
  input logic            rst_n_in,
  des_key_sched_if.slave bus
);
  localparam des_idx_t LAST = des_idx_t'(ROUNDS - 1);
  des_state_t state_q, state_d;
  des_idx_t   cnt_q, cnt_d, idx_q, idx_d;
  des_cd56_t  key_q, key_d, pc1_cd;
  logic       dir_q, dir_d, valid_q, valid_d, done_q, done_d, perr_q, perr_d;
  logic       par_ok, last;
  des_pc1 u_pc1 (.key_i(bus.key_in), .cd_o(pc1_cd));
`ifdef DES_KEY_PARITY_CHK_EN
  logic [7:0] byte_odd;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_odd[b] = ^bus.key_in[8*b +: 8];
  end
  assign par_ok = &byte_odd;
`else
  assign par_ok = 1'b1;
`endif
  assign last = cnt_q == (dir_q ? 4'd0 : LAST);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    key_d   = key_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.key_in_valid) begin
        perr_d = !par_ok;
        if (par_ok) begin
          state_d = S_RUN;
          key_d   = pc1_cd;
          dir_d   = bus.decrypt_in;
          cnt_d   = bus.decrypt_in ? LAST : 4'd0;
        end
      end
    end else if (bus.abort_in) begin
      state_d = S_IDLE;
    end else if (bus.round_en_in) begin
      valid_d = 1'b1;
      idx_d   = cnt_q;
      done_d  = last;
      cnt_d   = dir_q ? cnt_q - 4'd1 : cnt_q + 4'd1;
      state_d = last ? S_IDLE : S_RUN;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end
  assign bus.key_in_ready      = state_q == S_IDLE;
  assign bus.sched_busy_out    = state_q == S_RUN;
  assign bus.sub_key_out       = key_q;
  assign bus.sub_key_idx_out   = idx_q;
  assign bus.sub_key_out_valid = valid_q;
  assign bus.sched_done_out    = done_q;
  assign bus.parity_err_out    = perr_q;
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed checks of key acceptance, beat ordering, gaps, abort, reset and parity
module tb_des_key_sched;
  localparam logic [63:0] K1   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KBAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] K01  = 64'h0101010101010101;
  localparam logic [55:0] KP   = 56'hF0CCAAF556678F;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  des_key_sched_if bus ();
  des_key_sched dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic accept(input logic [63:0] k, input logic dec);
    bus.key_in       = k;
    bus.decrypt_in   = dec;
    bus.key_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_in_valid = 1'b0;
  endtask

  task automatic drop_run();
    bus.abort_in = 1'b1;
    @(posedge clk); #1;
    bus.abort_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.key_in = '0; bus.key_in_valid = 0; bus.decrypt_in = 0; bus.round_en_in = 0; bus.abort_in = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.key_in_ready !== 1 || bus.sched_busy_out !== 0 || bus.sub_key_out_valid !== 0 ||
        bus.sched_done_out !== 0 || bus.parity_err_out !== 0 || bus.sub_key_out !== 0 || bus.sub_key_idx_out !== 0)
      begin errors++; $display("FAIL reset: rdy=%b busy=%b v=%b done=%b perr=%b key=%h idx=%0d, want 1 0 0 0 0 0 0",
        bus.key_in_ready, bus.sched_busy_out, bus.sub_key_out_valid, bus.sched_done_out, bus.parity_err_out, bus.sub_key_out, bus.sub_key_idx_out); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.key_in_ready !== 1 || bus.sched_busy_out !== 0)
      begin errors++; $display("FAIL reset_release: rdy=%b busy=%b, want 1 0", bus.key_in_ready, bus.sched_busy_out); end
  endtask

  task automatic test_encrypt();
    bus.round_en_in = 1'b1;
    accept(K1, 1'b0);
    checks++;
    if (bus.sched_busy_out !== 1 || bus.key_in_ready !== 0 || bus.sub_key_out_valid !== 0)
      begin errors++; $display("FAIL enc_accept: busy=%b rdy=%b v=%b, want 1 0 0", bus.sched_busy_out, bus.key_in_ready, bus.sub_key_out_valid); end
    checks++;
    if (bus.sub_key_out !== KP)
      begin errors++; $display("FAIL enc_pc1: got %h want %h", bus.sub_key_out, KP); end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.sub_key_out_valid !== 1 || bus.sub_key_idx_out !== i[3:0] || bus.sched_done_out !== (i == 15))
        begin errors++; $display("FAIL enc_beat%0d: v=%b idx=%0d done=%b, want 1 %0d %b", i, bus.sub_key_out_valid, bus.sub_key_idx_out, bus.sched_done_out, i, i == 15); end
    end
    checks++;
    if (bus.key_in_ready !== 1 || bus.sched_busy_out !== 0)
      begin errors++; $display("FAIL enc_end: rdy=%b busy=%b, want 1 0", bus.key_in_ready, bus.sched_busy_out); end
    @(posedge clk); #1;
    checks++;
    if (bus.sub_key_out_valid !== 0 || bus.sched_done_out !== 0 || bus.sub_key_out !== KP)
      begin errors++; $display("FAIL enc_after: v=%b done=%b key=%h, want 0 0 %h", bus.sub_key_out_valid, bus.sched_done_out, bus.sub_key_out, KP); end
  endtask

  task automatic test_decrypt();
    bus.round_en_in = 1'b1;
    accept(K1, 1'b1);
    checks++;
    if (bus.sched_busy_out !== 1 || bus.sub_key_out !== KP)
      begin errors++; $display("FAIL dec_accept: busy=%b key=%h, want 1 %h", bus.sched_busy_out, bus.sub_key_out, KP); end
    for (int i = 0; i < 16; i++) begin
      int e = 15 - i;
      @(posedge clk); #1;
      checks++;
      if (bus.sub_key_out_valid !== 1 || bus.sub_key_idx_out !== e[3:0] || bus.sched_done_out !== (e == 0))
        begin errors++; $display("FAIL dec_beat%0d: v=%b idx=%0d done=%b, want 1 %0d %b", i, bus.sub_key_out_valid, bus.sub_key_idx_out, bus.sched_done_out, e, e == 0); end
    end
    checks++;
    if (bus.key_in_ready !== 1)
      begin errors++; $display("FAIL dec_end: rdy=%b want 1", bus.key_in_ready); end
  endtask

  task automatic test_gaps();
    int exp_i = 0;
    int c = 0;
    logic en;
    bus.round_en_in = 1'b0;
    accept(K1, 1'b0);
    bus.key_in = K01;
    bus.key_in_valid = 1'b1;
    while (exp_i < 16 && c < 100) begin
      en = (c % 3 == 0);
      bus.round_en_in = en;
      @(posedge clk); #1;
      checks++;
      if (en) begin
        if (bus.sub_key_out_valid !== 1 || bus.sub_key_idx_out !== exp_i[3:0] || bus.sched_done_out !== (exp_i == 15) || bus.sub_key_out !== KP)
          begin errors++; $display("FAIL gap_beat%0d: v=%b idx=%0d done=%b key=%h", exp_i, bus.sub_key_out_valid, bus.sub_key_idx_out, bus.sched_done_out, bus.sub_key_out); end
        exp_i++;
      end else if (bus.sub_key_out_valid !== 0 || bus.sched_done_out !== 0 || bus.sub_key_out !== KP) begin
        errors++; $display("FAIL gap_idle%0d: v=%b done=%b key=%h, want 0 0 %h", c, bus.sub_key_out_valid, bus.sched_done_out, bus.sub_key_out, KP);
      end
      c++;
    end
    bus.key_in_valid = 1'b0;
    checks++;
    if (exp_i != 16 || bus.sched_busy_out !== 0)
      begin errors++; $display("FAIL gap_count: beats=%0d busy=%b, want 16 0", exp_i, bus.sched_busy_out); end
  endtask

  task automatic test_abort();
    bus.round_en_in = 1'b1;
    accept(K1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.sub_key_out_valid !== 1 || bus.sub_key_idx_out !== i[3:0])
        begin errors++; $display("FAIL abort_beat%0d: v=%b idx=%0d", i, bus.sub_key_out_valid, bus.sub_key_idx_out); end
    end
    drop_run();
    checks++;
    if (bus.sub_key_out_valid !== 0 || bus.sched_done_out !== 0 || bus.sched_busy_out !== 0 || bus.key_in_ready !== 1 || bus.sub_key_out !== KP)
      begin errors++; $display("FAIL abort_stop: v=%b done=%b busy=%b rdy=%b key=%h", bus.sub_key_out_valid, bus.sched_done_out, bus.sched_busy_out, bus.key_in_ready, bus.sub_key_out); end
    accept(K01, 1'b0);
    checks++;
    if (bus.sched_busy_out !== 1 || bus.sub_key_out !== 56'h0)
      begin errors++; $display("FAIL abort_newkey: busy=%b key=%h, want 1 0", bus.sched_busy_out, bus.sub_key_out); end
    @(posedge clk); #1;
    checks++;
    if (bus.sub_key_out_valid !== 1 || bus.sub_key_idx_out !== 4'd0)
      begin errors++; $display("FAIL abort_restart: v=%b idx=%0d, want 1 0", bus.sub_key_out_valid, bus.sub_key_idx_out); end
    drop_run();
  endtask

  task automatic test_rst_mid();
    bus.round_en_in = 1'b1;
    accept(K1, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.key_in_ready !== 1 || bus.sched_busy_out !== 0 || bus.sub_key_out_valid !== 0 ||
        bus.sched_done_out !== 0 || bus.sub_key_out !== 0 || bus.sub_key_idx_out !== 0)
      begin errors++; $display("FAIL rst_mid: rdy=%b busy=%b v=%b done=%b key=%h idx=%0d", bus.key_in_ready, bus.sched_busy_out, bus.sub_key_out_valid, bus.sched_done_out, bus.sub_key_out, bus.sub_key_idx_out); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.key_in_ready !== 1 || bus.sched_busy_out !== 0 || bus.sub_key_out_valid !== 0)
      begin errors++; $display("FAIL rst_release: rdy=%b busy=%b v=%b, want 1 0 0", bus.key_in_ready, bus.sched_busy_out, bus.sub_key_out_valid); end
  endtask

  task automatic test_parity();
    bus.round_en_in = 1'b0;
    accept(KBAD, 1'b0);
`ifdef DES_KEY_PARITY_CHK_EN
    checks++;
    if (bus.parity_err_out !== 1 || bus.sched_busy_out !== 0 || bus.key_in_ready !== 1)
      begin errors++; $display("FAIL par_bad: perr=%b busy=%b rdy=%b, want 1 0 1", bus.parity_err_out, bus.sched_busy_out, bus.key_in_ready); end
    @(posedge clk); #1;
    checks++;
    if (bus.parity_err_out !== 0)
      begin errors++; $display("FAIL par_pulse: perr=%b want 0", bus.parity_err_out); end
    accept(K1, 1'b0);
    checks++;
    if (bus.parity_err_out !== 0 || bus.sched_busy_out !== 1 || bus.sub_key_out !== KP)
      begin errors++; $display("FAIL par_good: perr=%b busy=%b key=%h", bus.parity_err_out, bus.sched_busy_out, bus.sub_key_out); end
`else
    checks++;
    if (bus.parity_err_out !== 0 || bus.sched_busy_out !== 1 || bus.sub_key_out !== KP)
      begin errors++; $display("FAIL par_off: perr=%b busy=%b key=%h, want 0 1 %h", bus.parity_err_out, bus.sched_busy_out, bus.sub_key_out, KP); end
`endif
    drop_run();
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_gaps();
    test_abort();
    test_rst_mid();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
